fpu_spi_frontend: RTL and testbench

SPI mode-0 slave front end, clocked on SCLK. Sits directly upstream of the FPU control FSM, which runs in the clk domain.
- Decodes framed SPI transactions: an 8-bit command byte, then payload.
- Presents a complete operation (opcode, a, b) to the clk domain via a toggle handshake.
- Returns the FPU result to the master through a read-result frame.
- All cross-domain signalling uses toggles plus a synchroniser; no multi-bit bus is sampled unsynchronised.

---
 rtl/fpu_spi_pkg.sv | 14 +
 rtl/toggle_sync.sv | 15 +
 rtl/fpu_spi_frontend.sv | 106 ++++++++++
 tb/tb_fpu_spi_frontend.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_spi_pkg.sv
// fpu_spi_pkg: shared types and frame sizes; FPU_SPI_PARITY_EN adds one parity bit to each frame.
package fpu_spi_pkg;
  typedef enum logic [1:0] {ADD = 2'd0, SUB = 2'd1, MUL = 2'd2, DIV = 2'd3} op_t;
  typedef enum logic [1:0] {S_CMD, S_WR, S_RD, S_IGN} spi_state_t;
  localparam logic [7:0] CMD_WR = 8'hA1;
  localparam logic [7:0] CMD_RD = 8'hB2;
`ifdef FPU_SPI_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  localparam int WR_FRAME_BITS = 2 + 2 * 32 + PAR_BITS;
  localparam int RD_FRAME_BITS = 32 + 2 + PAR_BITS;
endpackage

// File: rtl/toggle_sync.sv
// toggle_sync: STAGES-deep flop chain carrying a toggle into the local clock domain.
module toggle_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;
  always_ff @(posedge clk or posedge rst)
    if (rst) chain <= '0;
    else chain <= {chain[STAGES-2:0], d};
  assign q = chain[STAGES-1];
endmodule

// File: rtl/fpu_spi_frontend.sv
// fpu_spi_frontend: SPI mode-0 slave framing FPU write/read-result transactions; FPU_SPI_PARITY_EN enables even parity.
module fpu_spi_frontend
  import fpu_spi_pkg::*;
#(
  parameter int DW          = 32,
  parameter int OPW         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic           SCLK,
  input  logic           rst,
  input  logic           CS_N,
  input  logic           MOSI,
  output logic           MISO,
  output logic [OPW-1:0] cmd_opcode,
  output logic [DW-1:0]  cmd_a,
  output logic [DW-1:0]  cmd_b,
  output logic           cmd_toggle,
  input  logic [DW-1:0]  res_data,
  input  logic           res_err,
  input  logic           res_toggle,
  output logic           frame_err
);
  localparam int PW      = OPW + 2 * DW;
  localparam int WR_BITS = PW + PAR_BITS;
  localparam int RD_BITS = DW + 2 + PAR_BITS;
  spi_state_t         state;
  logic [6:0]         bit_cnt;
  logic [6:0]         cmd_shift;
  logic [WR_BITS-2:0] rx_shift;
  logic [RD_BITS-1:0] tx_shift;
  logic [7:0]         cmd_byte;
  logic [WR_BITS-1:0] wr_word;
  logic [RD_BITS-1:0] rd_word;
  logic res_sync, res_seen, wr_busy, ready, par_ok, cmd_done, wr_done, rd_done, bad_cmd;
  toggle_sync #(.STAGES(SYNC_STAGES)) u_sync (.clk(SCLK), .rst(rst), .d(res_toggle), .q(res_sync));
  assign cmd_byte = {cmd_shift, MOSI};
  assign wr_word  = {rx_shift, MOSI};
  assign ready    = res_sync != res_seen;
  assign cmd_done = state == S_CMD && bit_cnt == 7'd7;
  assign wr_done  = state == S_WR && bit_cnt == 7'(WR_BITS - 1);
  assign rd_done  = state == S_RD && bit_cnt == 7'(RD_BITS - 1);
  assign bad_cmd  = cmd_done && cmd_byte != CMD_WR && cmd_byte != CMD_RD;
`ifdef FPU_SPI_PARITY_EN
  assign par_ok  = ~^wr_word;
  assign rd_word = {ready, res_err, res_data, ^{ready, res_err, res_data}};
`else
  assign par_ok  = 1'b1;
  assign rd_word = {ready, res_err, res_data};
`endif
  // Frame sequencing; a deasserted chip select restarts the frame at once.
  always_ff @(posedge SCLK or posedge rst or posedge CS_N)
    if (rst || CS_N) begin
      state     <= S_CMD;
      bit_cnt   <= '0;
      MISO      <= 1'b0;
      cmd_shift <= '0;
      rx_shift  <= '0;
      tx_shift  <= '0;
    end else begin
      case (state)
        S_CMD: begin
          cmd_shift <= cmd_byte[6:0];
          bit_cnt   <= cmd_done ? 7'd0 : bit_cnt + 7'd1;
          if (cmd_done) begin
            state    <= cmd_byte == CMD_WR ? S_WR : cmd_byte == CMD_RD ? S_RD : S_IGN;
            MISO     <= cmd_byte == CMD_RD && rd_word[RD_BITS-1];
            tx_shift <= rd_word << 1;
          end
        end
        S_WR: begin
          rx_shift <= wr_word[WR_BITS-2:0];
          bit_cnt  <= bit_cnt + 7'd1;
          if (wr_done) state <= S_IGN;
        end
        S_RD: begin
          MISO     <= !rd_done && tx_shift[RD_BITS-1];
          tx_shift <= tx_shift << 1;
          bit_cnt  <= bit_cnt + 7'd1;
          if (rd_done) state <= S_IGN;
        end
        default: begin
          MISO    <= 1'b0;
          bit_cnt <= bit_cnt == 7'h7f ? bit_cnt : bit_cnt + 7'd1;
        end
      endcase
    end
  // wr_busy survives chip select so an abandoned write is flagged at the next frame's first edge.
  always_ff @(posedge SCLK or posedge rst)
    if (rst) begin
      cmd_opcode <= '0;
      cmd_a      <= '0;
      cmd_b      <= '0;
      cmd_toggle <= 1'b0;
      frame_err  <= 1'b0;
      res_seen   <= 1'b0;
      wr_busy    <= 1'b0;
    end else begin
      wr_busy   <= state == S_CMD ? cmd_done && cmd_byte == CMD_WR : wr_busy && !wr_done;
      frame_err <= rd_done ? 1'b0 : frame_err | (wr_busy && state == S_CMD) | bad_cmd | (wr_done && !par_ok);
      if (wr_done && par_ok) begin
        {cmd_opcode, cmd_a, cmd_b} <= wr_word[WR_BITS-1 -: PW];
        cmd_toggle <= !cmd_toggle;
      end
      if (rd_done) res_seen <= res_sync;
    end
endmodule

// File: tb/tb_fpu_spi_frontend.sv
// tb_fpu_spi_frontend: randomized SPI frames checked by a frame-level model through a scoreboard.
`timescale 1ns/1ps
module tb_fpu_spi_frontend;
  import fpu_spi_pkg::*;
  localparam int WRB = WR_FRAME_BITS;
  localparam int RDB = RD_FRAME_BITS;
  logic SCLK = 1'b0, rst = 1'b0, CS_N = 1'b1, MOSI = 1'b0, sclk_en = 1'b0;
  logic MISO, cmd_toggle, frame_err;
  logic res_err = 1'b0, res_toggle = 1'b0;
  logic [1:0] cmd_opcode;
  logic [31:0] cmd_a, cmd_b;
  logic [31:0] res_data = '0;
  int vectors = 0, miscompares = 0;
  logic [65:0] wr_q[$];
  logic [RDB-1:0] rd_q[$];
  logic mosi_q[$], miso_q[$];
  logic tog_seen = 1'b0;
  logic m_tog = 1'b0, m_err = 1'b0, m_pend = 1'b0, m_seen = 1'b0;
  logic [7:0] fe_cmd;
  logic [RDB-1:0] fe_word;
  logic fe_any;

  fpu_spi_frontend dut (
    .SCLK(SCLK), .rst(rst), .CS_N(CS_N), .MOSI(MOSI), .MISO(MISO),
    .cmd_opcode(cmd_opcode), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_toggle(cmd_toggle),
    .res_data(res_data), .res_err(res_err), .res_toggle(res_toggle), .frame_err(frame_err)
  );

  always begin
    #5;
    SCLK = sclk_en ? !SCLK : 1'b0;
  end

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: records each bit pair and checks every commit against the write scoreboard.
  always @(posedge SCLK or posedge rst) begin
    if (rst) tog_seen = 1'b0;
    else begin
      #1;
      if (!CS_N) begin
        mosi_q.push_back(MOSI);
        miso_q.push_back(MISO);
      end
      if (cmd_toggle !== tog_seen) begin
        tog_seen = cmd_toggle;
        if (wr_q.size() == 0) check("unexpected_commit", 1, 0);
        else begin
          check("commit_cmd", {cmd_opcode, cmd_a, cmd_b}, wr_q.pop_front());
          check("commit_edge", mosi_q.size(), 8 + WRB);
        end
      end
    end
  end

  // Frame-end monitor: read frames against the read scoreboard, all other frames keep MISO low.
  always @(posedge CS_N) begin
    if (mosi_q.size() >= 8) begin
      fe_cmd = '0;
      for (int i = 0; i < 8; i++) fe_cmd = {fe_cmd[6:0], mosi_q[i]};
      if (fe_cmd == CMD_RD && miso_q.size() >= 8 + RDB) begin
        fe_word = '0;
        for (int i = 0; i < RDB; i++) fe_word = {fe_word[RDB-2:0], miso_q[7+i]};
        if (rd_q.size() == 0) check("unexpected_read", 1, 0);
        else check("read_word", fe_word, rd_q.pop_front());
      end else if (fe_cmd != CMD_RD) begin
        fe_any = 1'b0;
        foreach (miso_q[i]) fe_any |= miso_q[i];
        check("miso_idle", fe_any, 0);
      end
    end
    mosi_q.delete();
    miso_q.delete();
  end

  task automatic frame(input logic [7:0] cmd, input logic [127:0] pl, input int plen,
                       input int nedges, input int rst_at);
    logic [127:0] bits;
    int n;
    n = 8 + plen;
    bits = (128'(cmd) << plen) | pl;
    MOSI = bits[n-1];
    CS_N = 1'b0;
    #7;
    sclk_en = 1'b1;
    for (int i = 0; i < nedges; i++) begin
      @(negedge SCLK);
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        check("rst_outputs", {MISO, cmd_toggle, frame_err, cmd_opcode, cmd_a, cmd_b}, 0);
        rst = 1'b0;
        break;
      end
      MOSI = (i + 1 < n) ? bits[n-2-i] : 1'b0;
    end
    sclk_en = 1'b0;
    #3;
    CS_N = 1'b1;
    MOSI = 1'b0;
    #20;
  endtask

  task automatic frame_start();
    if (m_pend) begin
      m_err = 1'b1;
      m_pend = 1'b0;
    end
  endtask

  task automatic post(input int rst_at);
    if (rst_at >= 0) begin
      m_tog = 1'b0;
      m_err = 1'b0;
      m_pend = 1'b0;
      m_seen = 1'b0;
    end
    check("cmd_toggle", cmd_toggle, m_tog);
    check("frame_err", frame_err, m_err);
  endtask

  task automatic do_write(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic bad_par, input int nedges, input int rst_at);
    logic [127:0] pl;
    logic bad;
    bad = bad_par && PAR_BITS != 0;
    pl = PAR_BITS != 0 ? {61'b0, op, a, b, ^{op, a, b} ^ bad} : {62'b0, op, a, b};
    frame_start();
    if (rst_at < 0 && nedges >= 8 + WRB) begin
      if (bad) m_err = 1'b1;
      else begin
        wr_q.push_back({op, a, b});
        m_tog = !m_tog;
      end
    end else if (nedges >= 8) m_pend = 1'b1;
    frame(CMD_WR, pl, WRB, nedges, rst_at);
    post(rst_at);
  endtask

  task automatic do_read(input int nedges);
    logic [33:0] w;
    frame_start();
    if (nedges >= 8 + RDB) begin
      w = {res_toggle != m_seen, res_err, res_data};
`ifdef FPU_SPI_PARITY_EN
      rd_q.push_back({w, ^w});
`else
      rd_q.push_back(w);
`endif
      m_seen = res_toggle;
      m_err = 1'b0;
    end
    frame(CMD_RD, '0, 0, nedges, -1);
    post(-1);
  endtask

  task automatic do_bad(input logic [7:0] cmd, input int nedges);
    frame_start();
    if (nedges >= 8) m_err = 1'b1;
    frame(cmd, '0, 0, nedges, -1);
    post(-1);
  endtask

  task automatic new_result(input logic [31:0] d, input logic e);
    res_data = d;
    res_err = e;
    res_toggle = !res_toggle;
    #10;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] bc;
    rst = 1'b1;
    #10;
    check("reset_state", {MISO, cmd_toggle, frame_err, cmd_opcode, cmd_a, cmd_b}, 0);
    rst = 1'b0;
    #10;
    do_write(2'd2, 32'h3F800000, 32'h40000000, 1'b0, 8 + WRB, -1);
    new_result(32'h40000000, 1'b0);
    do_read(8 + RDB);
    do_read(8 + RDB);
    do_write(2'd1, 32'h12345678, 32'h9ABCDEF0, 1'b0, 8 + 40, -1);
    do_read(20);
    do_read(8 + RDB);
    do_bad(8'h5C, 8 + WRB);
    do_write(2'd3, 32'hDEADBEEF, 32'h0BADF00D, 1'b0, 8 + WRB, 37);
    do_write(2'd0, 32'hC0000000, 32'h3F000000, 1'b0, 8 + WRB, -1);
`ifdef FPU_SPI_PARITY_EN
    do_write(2'd2, 32'h11111111, 32'h22222222, 1'b1, 8 + WRB, -1);
    do_write(2'd2, 32'h11111111, 32'h22222222, 1'b0, 8 + WRB, -1);
    new_result(32'h7FC00001, 1'b1);
    do_read(8 + RDB);
`endif
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(5, 0))
        0, 1: do_write(2'($urandom), $urandom, $urandom, 1'($urandom_range(5, 0) == 0), 8 + WRB, -1);
        2: do_write(2'($urandom), $urandom, $urandom, 1'b0, $urandom_range(8 + WRB - 1, 1), -1);
        3: begin
          if ($urandom_range(1, 0) == 1) new_result($urandom, 1'($urandom));
          do_read(8 + RDB);
        end
        4: do_read($urandom_range(8 + RDB - 1, 1));
        default: begin
          bc = 8'($urandom);
          if (bc == CMD_WR || bc == CMD_RD) bc ^= 8'h01;
          do_bad(bc, $urandom_range(8 + WRB, 8));
        end
      endcase
    end
    #20;
    check("wr_queue_drained", wr_q.size(), 0);
    check("rd_queue_drained", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
